// File: rtl/instr_seg_fifo.sv
// Multi-lane instruction FIFO: each lane fills independently, and an instruction becomes
// visible once every lane holds its segment. Output is first-word fall-through.
module instr_seg_fifo #(
    parameter int unsigned FIFO_DEPTH  = 32,
    parameter int unsigned NUM_SEGS    = 3,
    parameter int unsigned SEG_WIDTH   = 32,
    parameter int unsigned INSTR_WIDTH = 80,
    parameter int unsigned AF_THRESH   = FIFO_DEPTH - 2
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_SEGS*SEG_WIDTH-1:0]        seg_data,
    input  logic [NUM_SEGS-1:0]                  seg_we,
    input  logic                                 flush,
    output logic [INSTR_WIDTH-1:0]               instr_out,
    output logic                                 instr_valid,
    input  logic                                 instr_ready,
    output logic                                 empty,
    output logic                                 full,
    output logic                                 almost_full,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]      count,
    output logic                                 overflow
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

    typedef logic [PW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    logic [SEG_WIDTH-1:0] mem_q [NUM_SEGS][FIFO_DEPTH];

    ptr_t                wr_ptr_q   [NUM_SEGS];
    ptr_t                wr_ptr_d   [NUM_SEGS];
    cnt_t                lane_cnt_q [NUM_SEGS];
    cnt_t                lane_cnt_d [NUM_SEGS];
    ptr_t                rd_ptr_q, rd_ptr_d;
    cnt_t                count_q, count_d;
    logic                ovf_q, ovf_d;
    logic [NUM_SEGS-1:0] accept;
    logic                pop;

    assign pop = (count_q != '0) && instr_ready;

    always_comb begin
        accept   = '0;
        rd_ptr_d = rd_ptr_q;
        ovf_d    = ovf_q;
        count_d  = cnt_t'(FIFO_DEPTH);
        for (int i = 0; i < NUM_SEGS; i++) begin
            wr_ptr_d[i]   = wr_ptr_q[i];
            lane_cnt_d[i] = lane_cnt_q[i];
        end
        if (flush) begin
            rd_ptr_d = '0;
            ovf_d    = 1'b0;
            for (int i = 0; i < NUM_SEGS; i++) begin
                wr_ptr_d[i]   = '0;
                lane_cnt_d[i] = '0;
            end
        end else begin
            if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
            for (int i = 0; i < NUM_SEGS; i++) begin
                // A pop frees a slot in every lane, so a full lane can still take a write.
                accept[i] = seg_we[i] && ((lane_cnt_q[i] != cnt_t'(FIFO_DEPTH)) || pop);
                if (seg_we[i] && !accept[i]) ovf_d = 1'b1;
                if (accept[i]) wr_ptr_d[i] = wr_ptr_q[i] + 1'b1;
                lane_cnt_d[i] = lane_cnt_q[i] + cnt_t'(accept[i]) - cnt_t'(pop);
            end
        end
        // Complete instructions are limited by the lane holding the fewest segments.
        for (int i = 0; i < NUM_SEGS; i++) begin
            if (lane_cnt_d[i] < count_d) count_d = lane_cnt_d[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            for (int i = 0; i < NUM_SEGS; i++) begin
                wr_ptr_q[i]   <= '0;
                lane_cnt_q[i] <= '0;
            end
        end else begin
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            for (int i = 0; i < NUM_SEGS; i++) begin
                wr_ptr_q[i]   <= wr_ptr_d[i];
                lane_cnt_q[i] <= lane_cnt_d[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_SEGS; i++) begin
            if (accept[i] && !rst) begin
                mem_q[i][wr_ptr_q[i]] <= seg_data[i*SEG_WIDTH +: SEG_WIDTH];
            end
        end
    end

    always_comb begin
        instr_out = '0;
        for (int b = 0; b < INSTR_WIDTH; b++) begin
            instr_out[b] = mem_q[b / SEG_WIDTH][rd_ptr_q][b % SEG_WIDTH];
        end
    end

    always_comb begin
        full = 1'b0;
        for (int i = 0; i < NUM_SEGS; i++) begin
            if (lane_cnt_q[i] == cnt_t'(FIFO_DEPTH)) full = 1'b1;
        end
    end

    assign instr_valid = (count_q != '0);
    assign empty       = !instr_valid;
    assign almost_full = (int'(count_q) >= int'(AF_THRESH));
    assign count       = count_q;
    assign overflow    = ovf_q;

endmodule
